// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
//   Multi-ported general-purpose register file for the pipelined datapath.
//   NUM_RD combinational read ports with write-to-read bypass, two write ports
//   (port 1 has priority), optional hardwired-zero register 0, synchronous
//   clear, and a per-register pending-write scoreboard with a population count.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset (clears registers and busy bits)
//   rd_addr    : NUM_RD packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data    : NUM_RD packed read data (combinational, bypassed)
//   rd_busy    : per read port, registered busy bit of the addressed register
//   wr0_*      : write port 0 (enable / address / data)
//   wr1_*      : write port 1, wins over port 0 on equal addresses
//   rsv_en     : reserve enable, marks rsv_addr as pending
//   rsv_addr   : register to reserve
//   busy_count : registered number of pending registers
// -----------------------------------------------------------------------------
module param_register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic                           wr0_en,
    input  logic [ADDR_WIDTH-1:0]          wr0_addr,
    input  logic [DATA_WIDTH-1:0]          wr0_data,
    input  logic                           wr1_en,
    input  logic [ADDR_WIDTH-1:0]          wr1_addr,
    input  logic [DATA_WIDTH-1:0]          wr1_data,
    input  logic                           rsv_en,
    input  logic [ADDR_WIDTH-1:0]          rsv_addr,
    output logic [ADDR_WIDTH:0]            busy_count
);

    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam logic        HAS_ZERO = (ZERO_REG != 0);

    // Storage and scoreboard state
    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;

    // Qualified requests: reset suppresses them, and register 0 drops them
    // when it is hardwired.
    logic wr0_ok;
    logic wr1_ok;
    logic rsv_ok;

    always_comb begin
        wr0_ok = wr0_en && !rst && !(HAS_ZERO && (wr0_addr == '0));
        wr1_ok = wr1_en && !rst && !(HAS_ZERO && (wr1_addr == '0));
        rsv_ok = rsv_en && !rst && !(HAS_ZERO && (rsv_addr == '0));
    end

    // Next scoreboard: writes retire producers, a same-edge reserve re-arms
    // the bit because the new producer supersedes the one being written back.
    always_comb begin
        busy_d = busy_q;
        if (wr0_ok) begin
            busy_d[wr0_addr] = 1'b0;
        end
        if (wr1_ok) begin
            busy_d[wr1_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // Population count of the next busy vector so the count tracks the bits
    // on the same edge. CNT_W bits hold DEPTH, so it cannot wrap.
    always_comb begin
        count_d = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            count_d = count_d + CNT_W'(busy_d[r]);
        end
    end

    // Scoreboard registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_count = count_q;

    // Register array; port 1 is written last so it wins on equal addresses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            if (wr0_ok) begin
                regs[wr0_addr] <= wr0_data;
            end
            if (wr1_ok) begin
                regs[wr1_addr] <= wr1_data;
            end
        end
    end

    // Read ports
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] word;
        logic                  is_zero;

        assign addr    = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign is_zero = HAS_ZERO && (addr == '0);

        // Bypass priority: hardwired zero, then port 1, then port 0, then array
        always_comb begin
            word = regs[addr];
            if (is_zero) begin
                word = '0;
            end else if (wr1_ok && (wr1_addr == addr)) begin
                word = wr1_data;
            end else if (wr0_ok && (wr0_addr == addr)) begin
                word = wr0_data;
            end
        end

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = word;

        // Busy is deliberately not bypassed: it reflects registered state only.
        assign rd_busy[i] = is_zero ? 1'b0 : busy_q[addr];
    end

endmodule

// File: tb/tb_param_register_file.sv
module tb_param_register_file;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr0_en;
    logic [4:0]  wr0_addr;
    logic [31:0] wr0_data;
    logic        wr1_en;
    logic [4:0]  wr1_addr;
    logic [31:0] wr1_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [5:0]  busy_count;

    // Second instance: ordinary register 0, small depth for the full-count corner
    logic        z_rst;
    logic [2:0]  z_rd_addr;
    logic [7:0]  z_rd_data;
    logic [0:0]  z_rd_busy;
    logic        z_wr0_en;
    logic [2:0]  z_wr0_addr;
    logic [7:0]  z_wr0_data;
    logic        z_wr1_en;
    logic [2:0]  z_wr1_addr;
    logic [7:0]  z_wr1_data;
    logic        z_rsv_en;
    logic [2:0]  z_rsv_addr;
    logic [3:0]  z_busy_count;

    int checks;
    int errors;

    param_register_file u_dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr0_en     (wr0_en),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .wr1_en     (wr1_en),
        .wr1_addr   (wr1_addr),
        .wr1_data   (wr1_data),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .busy_count (busy_count)
    );

    param_register_file #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3),
        .NUM_RD     (1),
        .ZERO_REG   (0)
    ) u_nz (
        .clk        (clk),
        .rst        (z_rst),
        .rd_addr    (z_rd_addr),
        .rd_data    (z_rd_data),
        .rd_busy    (z_rd_busy),
        .wr0_en     (z_wr0_en),
        .wr0_addr   (z_wr0_addr),
        .wr0_data   (z_wr0_data),
        .wr1_en     (z_wr1_en),
        .wr1_addr   (z_wr1_addr),
        .wr1_data   (z_wr1_data),
        .rsv_en     (z_rsv_en),
        .rsv_addr   (z_rsv_addr),
        .busy_count (z_busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        w0e;
        logic [4:0]  w0a;
        logic [31:0] w0d;
        logic        w1e;
        logic [4:0]  w1a;
        logic [31:0] w1d;
        logic        re;
        logic [4:0]  rsa;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [5:0]  ec;
    } vec_t;

    localparam int NV = 19;
    vec_t tv [NV];

    function automatic vec_t mk(
        input logic [4:0] ra0, input logic [4:0] ra1,
        input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
        input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
        input logic re, input logic [4:0] rsa,
        input logic [31:0] e0, input logic [31:0] e1,
        input logic [1:0] eb, input logic [5:0] ec);
        vec_t v;
        v.ra0 = ra0; v.ra1 = ra1;
        v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
        v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
        v.re  = re;  v.rsa = rsa;
        v.e0  = e0;  v.e1  = e1;  v.eb = eb; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus after the falling edge; outputs settle 1ns later,
    // well before the next rising edge.
    task automatic apply(input logic r, input vec_t v);
        @(negedge clk);
        rst      = r;
        rd_addr  = {v.ra1, v.ra0};
        wr0_en   = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d;
        wr1_en   = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d;
        rsv_en   = v.re;  rsv_addr = v.rsa;
        #1;
    endtask

    task automatic z_apply(input logic r, input logic [2:0] ra,
                           input logic we, input logic [2:0] wa, input logic [7:0] wd,
                           input logic re, input logic [2:0] rsa);
        @(negedge clk);
        z_rst      = r;
        z_rd_addr  = ra;
        z_wr0_en   = we; z_wr0_addr = wa; z_wr0_data = wd;
        z_rsv_en   = re; z_rsv_addr = rsa;
        #1;
    endtask

    vec_t idle;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; rd_addr = '0;
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        z_rst = 1'b1; z_rd_addr = '0;
        z_wr0_en = 1'b0; z_wr0_addr = '0; z_wr0_data = '0;
        z_wr1_en = 1'b0; z_wr1_addr = '0; z_wr1_data = '0;
        z_rsv_en = 1'b0; z_rsv_addr = '0;

        //            ra0 ra1 w0e w0a w0d           w1e w1a w1d           re rsa  e0            e1            eb     ec
        tv[0]  = mk(5,  31, 0, 0,  32'h0,         0, 0,  32'h0,         0, 0,  32'h0,        32'h0,        2'b00, 0);
        tv[1]  = mk(1,  5,  1, 1,  32'h0000FFFF,  0, 0,  32'h0,         0, 0,  32'h0000FFFF, 32'h0,        2'b00, 0);
        tv[2]  = mk(1,  30, 0, 0,  32'h0,         0, 0,  32'h0,         0, 0,  32'h0000FFFF, 32'h0,        2'b00, 0);
        tv[3]  = mk(30, 1,  1, 30, 32'h11111111,  1, 30, 32'hFFFF0000,  0, 0,  32'hFFFF0000, 32'h0000FFFF, 2'b00, 0);
        tv[4]  = mk(30, 0,  0, 0,  32'h0,         1, 0,  32'hDEADBEEF,  1, 0,  32'hFFFF0000, 32'h0,        2'b00, 0);
        tv[5]  = mk(0,  30, 0, 0,  32'h0,         0, 0,  32'h0,         0, 0,  32'h0,        32'hFFFF0000, 2'b00, 0);
        tv[6]  = mk(7,  0,  0, 0,  32'h0,         0, 0,  32'h0,         1, 7,  32'h0,        32'h0,        2'b00, 0);
        tv[7]  = mk(7,  0,  1, 7,  32'd42,        0, 0,  32'h0,         1, 7,  32'd42,       32'h0,        2'b01, 1);
        tv[8]  = mk(7,  0,  0, 0,  32'h0,         0, 0,  32'h0,         0, 0,  32'd42,       32'h0,        2'b01, 1);
        tv[9]  = mk(7,  7,  0, 0,  32'h0,         1, 7,  32'd9,         0, 0,  32'd9,        32'd9,        2'b11, 1);
        tv[10] = mk(7,  0,  0, 0,  32'h0,         0, 0,  32'h0,         0, 0,  32'd9,        32'h0,        2'b00, 0);
        tv[11] = mk(3,  4,  1, 3,  32'h123,       0, 0,  32'h0,         1, 4,  32'h123,      32'h0,        2'b00, 0);
        tv[12] = mk(3,  4,  0, 0,  32'h0,         0, 0,  32'h0,         0, 0,  32'h123,      32'h0,        2'b10, 1);
        tv[13] = mk(3,  4,  1, 4,  32'd5,         1, 3,  32'd6,         0, 0,  32'd6,        32'd5,        2'b10, 1);
        tv[14] = mk(3,  4,  0, 0,  32'h0,         0, 0,  32'h0,         0, 0,  32'd6,        32'd5,        2'b00, 0);
        tv[15] = mk(3,  4,  0, 0,  32'h0,         0, 0,  32'h0,         1, 4,  32'd6,        32'd5,        2'b00, 0);
        tv[16] = mk(3,  4,  0, 0,  32'h0,         0, 0,  32'h0,         1, 4,  32'd6,        32'd5,        2'b10, 1);
        tv[17] = mk(3,  4,  0, 0,  32'h0,         0, 0,  32'h0,         0, 0,  32'd6,        32'd5,        2'b10, 1);
        tv[18] = mk(3,  4,  1, 4,  32'd5,         0, 0,  32'h0,         0, 0,  32'd6,        32'd5,        2'b10, 1);
        idle   = mk(0,  0,  0, 0,  32'h0,         0, 0,  32'h0,         0, 0,  32'h0,        32'h0,        2'b00, 0);

        // Initial reset edge
        apply(1'b1, idle);

        for (int i = 0; i < NV; i++) begin
            apply(1'b0, tv[i]);
            chk($sformatf("v%0d rd_data0", i), rd_data[31:0],  tv[i].e0);
            chk($sformatf("v%0d rd_data1", i), rd_data[63:32], tv[i].e1);
            chk($sformatf("v%0d rd_busy", i),  32'(rd_busy),    32'(tv[i].eb));
            chk($sformatf("v%0d busy_count", i), 32'(busy_count), 32'(tv[i].ec));
        end

        // Reserve 1..20 on consecutive cycles, reset asserted on the 20th
        for (int k = 1; k <= 20; k++) begin
            vec_t v;
            v = idle;
            v.re  = 1'b1;
            v.rsa = 5'(k);
            apply(k == 20, v);
            chk($sformatf("rsv seq k%0d busy_count", k), 32'(busy_count), 32'(k - 1));
        end
        apply(1'b0, idle);
        chk("post reset busy_count", 32'(busy_count), 32'd0);
        for (int a = 0; a < 32; a++) begin
            vec_t v;
            v = idle;
            v.ra0 = 5'(a);
            v.ra1 = 5'(31 - a);
            apply(1'b0, v);
            chk($sformatf("post reset rd_data0 a%0d", a), rd_data[31:0], 32'h0);
            chk($sformatf("post reset rd_busy a%0d", a), 32'(rd_busy), 32'h0);
        end

        // Ordinary register 0 and full-depth count on the small instance
        z_apply(1'b1, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        z_apply(1'b0, 3'd0, 1'b1, 3'd0, 8'hA5, 1'b0, 3'd0);
        chk("nz bypass r0", 32'(z_rd_data), 32'h0A5);
        z_apply(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        chk("nz stored r0", 32'(z_rd_data), 32'h0A5);
        chk("nz busy r0 idle", 32'(z_rd_busy), 32'h0);
        for (int k = 0; k < 8; k++) begin
            z_apply(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 3'(k));
            chk($sformatf("nz count k%0d", k), 32'(z_busy_count), 32'(k));
        end
        z_apply(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        chk("nz full count", 32'(z_busy_count), 32'd8);
        chk("nz busy r0 reserved", 32'(z_rd_busy), 32'h1);
        z_apply(1'b1, 3'd0, 1'b1, 3'd0, 8'h3C, 1'b1, 3'd0);
        z_apply(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        chk("nz reset count", 32'(z_busy_count), 32'd0);
        chk("nz reset r0 data", 32'(z_rd_data), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
